// File: rtl/regfile_pkg.sv
// Shared constants and the write-port arbitration helper for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;
  localparam int MAX_WR     = 8;

  typedef logic [MAX_WR-1:0] wr_mask_t;

  // Scans from port 0 upward so the highest-index matching port is the one left standing.
  function automatic wr_mask_t pick_winner(input wr_mask_t match);
    wr_mask_t win;
    win = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (match[w]) begin
        win    = '0;
        win[w] = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue-set beats writeback-clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [(1<<ADDR_W)-1:0]   clr,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_next;

  // NOTE: every variable driven here gets a default on entry, so no path can infer a latch.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (clr[r]) busy_next[r] = 1'b0;
      if (set_en && (set_addr == ADDR_W'(r))) busy_next[r] = 1'b1;
      if ((ZERO_REG != 0) && (r == ZERO_ADDR)) busy_next[r] = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register pending-write scoreboard for the decode stage.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  output logic [NUM_RD-1:0]        ReadBusy,
  input  logic [NUM_WR*ADDR_W-1:0] WriteReg,
  input  logic [NUM_WR*DATA_W-1:0] WriteData,
  input  logic [NUM_WR-1:0]        RegWrite,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueReg,
  output logic [(1<<ADDR_W)-1:0]   BusyVec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [ADDR_W-1:0] wr_addr [NUM_WR];
  logic [DATA_W-1:0] wr_data [NUM_WR];
  logic [NUM_WR-1:0] wr_en;

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] reg_wd [DEPTH];
  logic [DEPTH-1:0]  reg_hit;
  logic [DEPTH-1:0]  reg_we;
  logic [DEPTH-1:0]  busy;

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) rd_addr[k] = ReadReg[k*ADDR_W +: ADDR_W];
    for (int w = 0; w < NUM_WR; w++) begin
      wr_addr[w] = WriteReg[w*ADDR_W +: ADDR_W];
      wr_data[w] = WriteData[w*DATA_W +: DATA_W];
    end
    // Writes are inert while reset is held, which also keeps the bypass from leaking data.
    wr_en = RegWrite & {NUM_WR{Rst_n}};
  end

  // Per-register arbitration: which port (if any) writes register r this cycle.
  always_comb begin
    wr_mask_t match;
    wr_mask_t win;
    match = '0;
    win   = '0;
    for (int r = 0; r < DEPTH; r++) begin
      match = '0;
      for (int w = 0; w < NUM_WR; w++) match[w] = wr_en[w] && (wr_addr[w] == ADDR_W'(r));
      win = pick_winner(match);
      reg_wd[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (win[w]) reg_wd[r] = wr_data[w];
      end
      reg_hit[r] = |match;
      reg_we[r]  = (|match) && !((ZERO_REG != 0) && (r == ZERO_ADDR));
    end
  end

  // NOTE: the storage array is reset explicitly; reset must leave every register reading 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (reg_we[r]) regs[r] <= reg_wd[r];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .set_en   (IssueEn),
    .set_addr (IssueReg),
    .clr      (reg_hit),
    .busy     (busy)
  );

  // Zero-register override is applied last so it beats the bypass.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    a        = '0;
    d        = '0;
    b        = 1'b0;
    ReadData = '0;
    ReadBusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = rd_addr[k];
      d = regs[a];
      b = busy[a];
      if ((BYPASS != 0) && reg_hit[a]) begin
        d = reg_wd[a];
        b = 1'b0;
      end
      if ((ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR))) d = '0;
      ReadData[k*DATA_W +: DATA_W] = d;
      ReadBusy[k]                  = b;
    end
  end

  assign BusyVec = busy;

endmodule
